// File: rtl/max7219_frame_seq.sv
// rtl/max7219_frame_seq.sv - MAX7219 init/frame command sequencer driving the serial transmitter
module max7219_frame_seq #(
  parameter int Freq_MegaHZ    = 50,
  parameter int PWRUP_US       = 100,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [63:0] frame,
  input  logic        frame_vld,
  input  logic [3:0]  intensity,
  input  logic        busy,
  output logic        str,
  output logic [7:0]  IRreg,
  output logic [7:0]  data,
  output logic        ready,
  output logic        init_done,
  output logic        frame_ack,
  output logic        err
);

  // Terminal counts for the single shared cycle counter.
  localparam logic [31:0] PWRUP_LAST = 32'(Freq_MegaHZ * PWRUP_US - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP
  } state_t;

  // Which command list the current index walks through.
  typedef enum logic [1:0] {
    K_INIT, K_FRAME, K_INTEN
  } kind_t;

  state_t      state, state_n;
  kind_t       kind, kind_n;
  logic [2:0]  idx, idx_n;
  logic [31:0] cnt, cnt_n;
  logic [63:0] buf_q, buf_n;
  logic [3:0]  last_int, last_int_n;
  logic        retry, retry_n;
  logic        str_n, ready_n, init_done_n, frame_ack_n, err_n;
  logic [7:0]  irreg_n, data_n;
  logic [7:0]  cmd_addr, cmd_data;

  // Address/data of the command selected by kind and index.
  always_comb begin
    cmd_addr = 8'h0C;
    cmd_data = 8'h01;
    case (kind)
      K_INIT: begin
        case (idx)
          3'd0:    begin cmd_addr = 8'h0C; cmd_data = 8'h00; end
          3'd1:    begin cmd_addr = 8'h09; cmd_data = 8'h00; end
          3'd2:    begin cmd_addr = 8'h0B; cmd_data = 8'h07; end
          3'd3:    begin cmd_addr = 8'h0A; cmd_data = {4'h0, intensity}; end
          default: begin cmd_addr = 8'h0C; cmd_data = 8'h01; end
        endcase
      end
      K_FRAME: begin
        cmd_addr = {5'd0, idx} + 8'd1;
        cmd_data = buf_q[{idx, 3'b000} +: 8];
      end
      default: begin
        cmd_addr = 8'h0A;
        cmd_data = {4'h0, intensity};
      end
    endcase
  end

  // Next-state and next-output logic for the sequencer and command handshake.
  always_comb begin
    state_n     = state;
    kind_n      = kind;
    idx_n       = idx;
    cnt_n       = cnt;
    buf_n       = buf_q;
    last_int_n  = last_int;
    retry_n     = retry;
    str_n       = str;
    irreg_n     = IRreg;
    data_n      = data;
    ready_n     = ready;
    init_done_n = init_done;
    frame_ack_n = 1'b0;
    err_n       = err;
    case (state)
      S_PWRUP: begin
        if (cnt == PWRUP_LAST) begin
          cnt_n   = '0;
          kind_n  = K_INIT;
          idx_n   = 3'd0;
          state_n = S_ISSUE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_IDLE: begin
        if (frame_vld) begin
          buf_n   = frame;
          ready_n = 1'b0;
          kind_n  = K_FRAME;
          idx_n   = 3'd0;
          state_n = S_ISSUE;
        end else if (intensity != last_int) begin
          ready_n = 1'b0;
          kind_n  = K_INTEN;
          idx_n   = 3'd0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        irreg_n = cmd_addr;
        data_n  = cmd_data;
        str_n   = 1'b1;
        if (cmd_addr == 8'h0A) last_int_n = intensity;
        retry_n = 1'b0;
        cnt_n   = '0;
        state_n = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (busy) begin
          cnt_n   = '0;
          state_n = S_WAIT_LO;
        end else if (cnt == TO_LAST) begin
          err_n   = 1'b1;
          str_n   = 1'b0;
          retry_n = 1'b1;
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_WAIT_LO: begin
        if (!busy) begin
          str_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_GAP;
        end else if (cnt == TO_LAST) begin
          err_n   = 1'b1;
          str_n   = 1'b0;
          retry_n = 1'b1;
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (retry) begin
            state_n = S_ISSUE;
          end else begin
            case (kind)
              K_INIT: begin
                if (idx == 3'd4) begin
                  init_done_n = 1'b1;
                  ready_n     = 1'b1;
                  state_n     = S_IDLE;
                end else begin
                  idx_n   = idx + 3'd1;
                  state_n = S_ISSUE;
                end
              end
              K_FRAME: begin
                if (idx == 3'd7) begin
                  frame_ack_n = 1'b1;
                  ready_n     = 1'b1;
                  state_n     = S_IDLE;
                end else begin
                  idx_n   = idx + 3'd1;
                  state_n = S_ISSUE;
                end
              end
              default: begin
                ready_n = 1'b1;
                state_n = S_IDLE;
              end
            endcase
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: begin
        state_n = S_PWRUP;
        cnt_n   = '0;
      end
    endcase
  end

  // State and registered outputs; reset restarts the power-up wait.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= S_PWRUP;
      kind      <= K_INIT;
      idx       <= 3'd0;
      cnt       <= '0;
      buf_q     <= '0;
      last_int  <= 4'h0;
      retry     <= 1'b0;
      str       <= 1'b0;
      IRreg     <= 8'h00;
      data      <= 8'h00;
      ready     <= 1'b0;
      init_done <= 1'b0;
      frame_ack <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      buf_q     <= buf_n;
      last_int  <= last_int_n;
      retry     <= retry_n;
      str       <= str_n;
      IRreg     <= irreg_n;
      data      <= data_n;
      ready     <= ready_n;
      init_done <= init_done_n;
      frame_ack <= frame_ack_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_max7219_frame_seq.sv
// tb/tb_max7219_frame_seq.sv - directed self-checking bench for max7219_frame_seq
module tb_max7219_frame_seq;

  localparam int FREQ    = 10;
  localparam int PWRUP   = 10;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 256;
  localparam int XFER    = 100;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [63:0] frame;
  logic        frame_vld;
  logic [3:0]  intensity;
  logic        busy;
  logic        str;
  logic [7:0]  IRreg;
  logic [7:0]  data;
  logic        ready;
  logic        init_done;
  logic        frame_ack;
  logic        err;

  max7219_frame_seq #(
    .Freq_MegaHZ(FREQ), .PWRUP_US(PWRUP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .frame(frame), .frame_vld(frame_vld),
    .intensity(intensity), .busy(busy), .str(str), .IRreg(IRreg), .data(data),
    .ready(ready), .init_done(init_done), .frame_ack(frame_ack), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model and protocol monitor, both on the falling edge.
  logic [15:0] cmd_q[$];
  int          gap_q[$];
  logic        prev_str = 1'b0;
  logic        stall = 1'b0;
  logic        in_cmd = 1'b0;
  logic [15:0] cur_cmd = 16'h0;
  int          low_len = 0;
  int          m_st = 0;
  int          m_cnt = 0;
  int          fall_busy_viol = 0;
  int          unstable = 0;
  int          ack_cnt = 0;
  int          ack_ready_bad = 0;

  always @(negedge sys_clk) begin
    if (rst) begin
      busy     = 1'b0;
      m_st     = 0;
      m_cnt    = 0;
      prev_str = 1'b0;
      in_cmd   = 1'b0;
      low_len  = 0;
    end else begin
      if (str && !prev_str) begin
        cmd_q.push_back({IRreg, data});
        gap_q.push_back(low_len);
        cur_cmd = {IRreg, data};
        in_cmd  = 1'b1;
      end
      if (!str && prev_str) begin
        if (busy) fall_busy_viol++;
        low_len = 1;
      end else if (!str) begin
        low_len++;
      end
      if (in_cmd && (str || low_len <= GAP + 1) && ({IRreg, data} != cur_cmd)) unstable++;
      if (frame_ack) begin
        ack_cnt++;
        if (!ready) ack_ready_bad++;
      end
      case (m_st)
        0: if (str && !stall) begin m_cnt = 0; m_st = 1; end
        1: begin
          m_cnt++;
          if (m_cnt == 3) begin busy = 1'b1; m_cnt = 0; m_st = 2; end
        end
        2: begin
          m_cnt++;
          if (m_cnt == XFER) begin busy = 1'b0; m_st = 3; end
        end
        default: if (!str) m_st = 0;
      endcase
      prev_str = str;
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return init_done;
      1:       return frame_ack;
      default: return err;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (get_sig(sel)) return;
    end
    check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_init_seq(input string tag, input logic [3:0] inten);
    logic [15:0] exp_init [5];
    exp_init[0] = 16'h0C00;
    exp_init[1] = 16'h0900;
    exp_init[2] = 16'h0B07;
    exp_init[3] = {8'h0A, 4'h0, inten};
    exp_init[4] = 16'h0C01;
    check_eq({tag, "_count"}, 64'(cmd_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < cmd_q.size()) check_eq($sformatf("%s_cmd%0d", tag, i), 64'(cmd_q[i]), 64'(exp_init[i]));
  endtask

  task automatic check_frame_cmds(input string tag, input logic [63:0] fv);
    for (int i = 0; i < 8; i++) begin
      if (i < cmd_q.size())
        check_eq($sformatf("%s_digit%0d", tag, i + 1), 64'(cmd_q[i]), 64'({8'(i + 1), fv[8*i +: 8]}));
      else
        check_eq($sformatf("%s_digit%0d_missing", tag, i + 1), 64'(cmd_q.size()), 64'(i + 1));
    end
  endtask

  logic [63:0] fa;
  logic [63:0] fb;

  initial begin
    rst       = 1'b1;
    frame     = 64'h0;
    frame_vld = 1'b0;
    intensity = 4'h8;
    repeat (3) tick();
    check_eq("rst_str", 64'(str), 64'd0);
    check_eq("rst_irreg", 64'(IRreg), 64'd0);
    check_eq("rst_data", 64'(data), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    check_eq("rst_frame_ack", 64'(frame_ack), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);

    rst = 1'b0;
    wait_sig(0, 5000, "init");
    tick();
    check_init_seq("init", 4'h8);
    check_eq("init_done", 64'(init_done), 64'd1);
    check_eq("init_ready", 64'(ready), 64'd1);
    for (int i = 1; i < 5; i++)
      if (i < gap_q.size()) check_eq($sformatf("init_gap%0d", i), 64'(gap_q[i]), 64'(GAP + 1));
    repeat (5) tick();

    // Single frame; frame input is scrambled after acceptance.
    cmd_q.delete(); gap_q.delete(); ack_cnt = 0;
    fa = 64'h8877665544332211;
    frame = fa; frame_vld = 1'b1;
    tick();
    frame_vld = 1'b0; frame = 64'hDEADBEEFCAFEF00D;
    check_eq("accept_ready_low", 64'(ready), 64'd0);
    check_eq("accept_str_low", 64'(str), 64'd0);
    tick();
    check_eq("digit1_str_rise", 64'(str), 64'd1);
    check_eq("digit1_cmd", 64'({IRreg, data}), 64'h0111);
    wait_sig(1, 3000, "frame_a");
    check_eq("ack_with_ready", 64'(ready), 64'd1);
    tick();
    check_eq("ack_one_cycle", 64'(frame_ack), 64'd0);
    repeat (20) tick();
    check_eq("frame_a_count", 64'(cmd_q.size()), 64'd8);
    check_frame_cmds("frame_a", fa);
    for (int i = 1; i < 8; i++)
      if (i < gap_q.size()) check_eq($sformatf("frame_gap%0d", i), 64'(gap_q[i]), 64'(GAP + 1));
    check_eq("frame_a_acks", 64'(ack_cnt), 64'd1);

    // Intensity update while idle.
    cmd_q.delete(); gap_q.delete();
    intensity = 4'h3;
    repeat (300) tick();
    check_eq("inten_count", 64'(cmd_q.size()), 64'd1);
    if (cmd_q.size() > 0) check_eq("inten_cmd", 64'(cmd_q[0]), 64'h0A03);
    check_eq("inten_ready", 64'(ready), 64'd1);

    // Frame and intensity change in the same cycle: frame goes first.
    cmd_q.delete(); gap_q.delete(); ack_cnt = 0;
    fb = 64'hF0E0D0C0B0A09080;
    frame = fb; frame_vld = 1'b1; intensity = 4'h5;
    tick();
    frame_vld = 1'b0;
    wait_sig(1, 3000, "frame_b");
    repeat (300) tick();
    check_eq("frame_b_count", 64'(cmd_q.size()), 64'd9);
    check_frame_cmds("frame_b", fb);
    if (cmd_q.size() > 8) check_eq("frame_b_inten", 64'(cmd_q[8]), 64'h0A05);
    check_eq("frame_b_acks", 64'(ack_cnt), 64'd1);

    // Stalled transmitter: timeout, error, then retry of the same command.
    cmd_q.delete(); gap_q.delete();
    stall = 1'b1; intensity = 4'h9;
    wait_sig(2, 2000, "stall_err");
    check_eq("stall_err", 64'(err), 64'd1);
    check_eq("stall_str_low", 64'(str), 64'd0);
    stall = 1'b0;
    repeat (300) tick();
    check_eq("retry_count", 64'(cmd_q.size()), 64'd2);
    if (cmd_q.size() > 1) begin
      check_eq("retry_cmd0", 64'(cmd_q[0]), 64'h0A09);
      check_eq("retry_cmd1", 64'(cmd_q[1]), 64'h0A09);
      check_eq("retry_gap", 64'(gap_q[1]), 64'(GAP + 1));
    end
    check_eq("err_sticky", 64'(err), 64'd1);
    check_eq("retry_ready", 64'(ready), 64'd1);

    // Reset during digit 4 of a frame.
    cmd_q.delete(); gap_q.delete(); ack_cnt = 0;
    frame = fa; frame_vld = 1'b1;
    tick();
    frame_vld = 1'b0;
    for (int i = 0; i < 3000 && cmd_q.size() < 4; i++) tick();
    check_eq("reach_digit4", 64'(cmd_q.size()), 64'd4);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_str", 64'(str), 64'd0);
    check_eq("mid_rst_irreg", 64'(IRreg), 64'd0);
    check_eq("mid_rst_data", 64'(data), 64'd0);
    check_eq("mid_rst_ready", 64'(ready), 64'd0);
    check_eq("mid_rst_init_done", 64'(init_done), 64'd0);
    check_eq("mid_rst_err", 64'(err), 64'd0);
    repeat (2) tick();
    cmd_q.delete(); gap_q.delete(); ack_cnt = 0;
    rst = 1'b0;
    wait_sig(0, 5000, "reinit");
    repeat (20) tick();
    check_init_seq("reinit", 4'h9);
    check_eq("reinit_no_ack", 64'(ack_cnt), 64'd0);
    check_eq("reinit_ready", 64'(ready), 64'd1);

    check_eq("str_fall_while_busy", 64'(fall_busy_viol), 64'd0);
    check_eq("cmd_unstable", 64'(unstable), 64'd0);
    check_eq("ack_without_ready", 64'(ack_ready_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
